instr_encoder: RTL and testbench

//  Encoder/loader for the RV32I fields that Control_unit_top decodes: accepts field-level instruction

---
 rtl/instr_encoder.sv | 118 +++++++++++
 tb/tb_instr_encoder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field-level descriptor encoder and instruction-memory loader
module instr_encoder #(
    parameter int ADDR_WIDTH = 6,
    parameter int MAX_WORDS  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [1:0]            fmt,
    input  logic [6:0]            Op,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [12:0]           imm,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CW = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] inflight;
    logic [31:0]   enc;
    logic          legal;
    logic          fire;

    // Words already committed to this session: completed writes plus the one still on the bus.
    assign inflight = {1'b0, count} + CW'(mem_we);
    assign in_ready = (state == S_RUN) && (inflight < CW'(MAX_WORDS));
    assign fire     = in_valid && in_ready;

    // Pack the descriptor fields into the RV32I bit layout selected by fmt.
    always_comb begin
        enc = '0;
        case (fmt)
            2'b00:   enc = {funct7, rs2, rs1, funct3, rd, Op};
            2'b01:   enc = {imm[11:0], rs1, funct3, rd, Op};
            2'b10:   enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], Op};
            default: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], Op};
        endcase
    end

    // I/S immediates must fit 12-bit signed; branch offsets must be halfword aligned.
    always_comb begin
        legal = 1'b1;
        case (fmt)
            2'b01, 2'b10: legal = (imm[12] == imm[11]);
            2'b11:        legal = ~imm[0];
            default:      legal = 1'b1;
        endcase
    end

    // Session FSM with registered flags and the one-cycle-delayed memory write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (mem_we) begin
                count <= count + 1'b1;
            end
            case (state)
                S_RUN: begin
                    if (fire) begin
                        if (legal) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= inflight[ADDR_WIDTH-1:0];
                            mem_wdata <= enc;
                            if (in_last || (inflight + 1'b1 == CW'(MAX_WORDS))) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            state <= S_ERR;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state <= S_RUN;
                        count <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized model-checked bench for instr_encoder
module tb_instr_encoder;

    localparam int AW   = 6;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [1:0]    fmt = '0;
    logic [6:0]    Op = '0;
    logic [2:0]    funct3 = '0;
    logic [6:0]    funct7 = '0;
    logic [4:0]    rd = '0;
    logic [4:0]    rs1 = '0;
    logic [4:0]    rs2 = '0;
    logic [12:0]   imm = '0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .fmt(fmt), .Op(Op), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .count(count), .busy(busy), .done(done), .err(err)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference encoder: builds the word from field values with shifts and masks.
    function automatic logic [31:0] model_enc(input int f, input int op, input int f3, input int f7,
                                              input int rdv, input int r1, input int r2, input int immv);
        logic [31:0] u;
        logic [31:0] common;
        u = immv;
        common = (r1 << 15) | (f3 << 12) | op;
        case (f)
            0:       return (f7 << 25) | (r2 << 20) | common | (rdv << 7);
            1:       return ((u & 32'hFFF) << 20) | common | (rdv << 7);
            2:       return (((u >> 5) & 32'h7F) << 25) | (r2 << 20) | common | ((u & 32'h1F) << 7);
            default: return (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (r2 << 20)
                          | common | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7);
        endcase
    endfunction

    function automatic bit model_legal(input int f, input int immv);
        if (f == 1 || f == 2) return (immv >= -2048) && (immv <= 2047);
        if (f == 3) return (immv % 2) == 0;
        return 1'b1;
    endfunction

    // Model state: phase 0 idle, 1 run, 2 done, 3 err; m_acc = legal words accepted this session.
    int          m_phase = 0;
    int          m_acc   = 0;
    int          m_count = 0;
    bit          m_we    = 1'b0;
    int          m_addr  = 0;
    logic [31:0] m_data  = '0;
    bit          m_fire  = 1'b0;
    int          m_imm;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_acc = 0; m_count = 0; m_we = 1'b0;
            m_addr = 0; m_data = '0; m_fire = 1'b0;
        end else begin
            if (m_we) m_count++;
            m_we   = 1'b0;
            m_fire = 1'b0;
            if (m_phase == 1) begin
                if (in_valid && m_acc < MAXW) begin
                    m_fire = 1'b1;
                    m_imm  = $signed(imm);
                    if (model_legal(int'(fmt), m_imm)) begin
                        m_we   = 1'b1;
                        m_addr = m_acc;
                        m_data = model_enc(int'(fmt), int'(Op), int'(funct3), int'(funct7),
                                           int'(rd), int'(rs1), int'(rs2), m_imm);
                        m_acc++;
                        if (in_last || m_acc == MAXW) m_phase = 2;
                    end else begin
                        m_phase = 3;
                    end
                end
            end else if (start) begin
                m_phase = 1; m_count = 0; m_acc = 0;
            end
        end
    end

    always @(posedge clk) cyc++;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          c;
    } wr_t;
    wr_t wlog[$];

    // Every cycle: DUT outputs against the model; also record observed writes.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("mem_wdata", mem_wdata, m_data);
            chk("count", 32'(count), 32'(m_count));
            chk("in_ready", 32'(in_ready), 32'(m_phase == 1 && m_acc < MAXW));
            chk("busy", 32'(busy), 32'(m_phase == 1));
            chk("done", 32'(done), 32'(m_phase == 2));
            chk("err", 32'(err), 32'(m_phase == 3));
        end
        if (mem_we === 1'b1) wlog.push_back('{int'(mem_addr), mem_wdata, cyc});
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [12:0] im, input logic last,
                        input logic st);
        bit ok;
        ok = 1'b0;
        fmt = f; Op = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_last = last; start = st; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (m_fire) begin ok = 1'b1; break; end
        end
        start = 1'b0;
        if (!ok) begin
            chk("send_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        logic [1:0]  rf;
        logic [12:0] rim;
        int          n;

        chk("pin_R", model_enc(0, 'h33, 0, 0, 3, 1, 2, 0), 32'h002081B3);
        chk("pin_I", model_enc(1, 'h13, 0, 0, 1, 0, 0, 5), 32'h00500093);
        chk("pin_S", model_enc(2, 'h23, 2, 0, 0, 0, 2, 8), 32'h00202423);
        chk("pin_B", model_enc(3, 'h63, 0, 0, 0, 1, 2, -4), 32'hFE208EE3);
        chk("pin_legal_I2048", 32'(model_legal(1, 2048)), 32'd0);

        repeat (3) begin @(posedge clk); #1; end
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_flags", 32'({busy, done, err}), 32'd0);
        chk_en = 1'b1;
        rst = 1'b1;
        idle(2);

        // R-type word lands one cycle after acceptance at address 0
        do_start();
        send(2'b00, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 1'b0);
        chk("t1_we", 32'(mem_we), 32'd1);
        chk("t1_addr", 32'(mem_addr), 32'd0);
        chk("t1_wdata", mem_wdata, 32'h002081B3);
        idle(3);

        // I then S back to back
        wlog.delete();
        do_start();
        send(2'b01, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0, 1'b0);
        send(2'b10, 7'h23, 3'd2, 7'd0, 5'd0, 5'd0, 5'd2, 13'd8, 1'b1, 1'b0);
        idle(3);
        chk("t2_nwr", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            chk("t2_w0", wlog[0].data, 32'h00500093);
            chk("t2_a1", 32'(wlog[1].addr), 32'd1);
            chk("t2_w1", wlog[1].data, 32'h00202423);
            chk("t2_consec", 32'(wlog[1].c - wlog[0].c), 32'd1);
        end
        chk("t2_count", 32'(count), 32'd2);

        // B-type with negative offset ends the program
        wlog.delete();
        do_start();
        send(2'b11, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 13'h1FFC, 1'b1, 1'b0);
        idle(2);
        chk("t3_nwr", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) chk("t3_w", wlog[0].data, 32'hFE208EE3);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);

        // out-of-range I immediate: no write, error held until start
        wlog.delete();
        do_start();
        send(2'b01, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'h0800, 1'b0, 1'b0);
        idle(4);
        chk("t4_nwr", 32'(wlog.size()), 32'd0);
        chk("t4_err", 32'(err), 32'd1);
        do_start();
        chk("t4_count", 32'(count), 32'd0);
        chk("t4_err_clr", 32'(err), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);

        // full: valid held for many cycles, only MAXW writes happen
        wlog.delete();
        fmt = 2'b01; Op = 7'h13; funct3 = 3'd0; rs1 = 5'd0; imm = 13'd7; in_last = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd = 5'(i);
            @(posedge clk); #1;
        end
        idle(2);
        chk("t5_nwr", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4; i++) if (wlog.size() > i) chk("t5_addr", 32'(wlog[i].addr), 32'(i));
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_in_ready", 32'(in_ready), 32'd0);
        chk("t5_count", 32'(count), 32'd4);

        // reset between accept and write suppresses the write
        do_start();
        wlog.delete();
        send(2'b00, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("t6_we", 32'(mem_we), 32'd0);
        chk("t6_addr", 32'(mem_addr), 32'd0);
        chk("t6_wdata", mem_wdata, 32'd0);
        chk("t6_flags", 32'({busy, done, err, in_ready}), 32'd0);
        chk("t6_count", 32'(count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(2);
        chk("t6_nwr", 32'(wlog.size()), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);

        // randomized sessions
        for (int s = 0; s < 60; s++) begin
            idle(2);
            do_start();
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                if (!(m_phase == 1 && m_acc < MAXW)) break;
                rf  = 2'($urandom_range(0, 3));
                rim = 13'($urandom);
                if ($urandom_range(0, 4) != 0) begin
                    if (rf == 2'b01 || rf == 2'b10) rim[12] = rim[11];
                    if (rf == 2'b11) rim[0] = 1'b0;
                end
                send(rf, 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
                     5'($urandom), rim, 1'((k == n - 1) && ($urandom_range(0, 1) == 1)),
                     1'($urandom_range(0, 7) == 0));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
